// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed 7-segment scan controller with blanking guard,
// frame-synchronous shadow update and leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_slot;
    logic [CNT_W-1:0]        w_slot_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;

    logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_active_bcd;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic                    r_pending;

    logic [3:0]              r_bcd_out;
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic                    r_dp_out;
    logic                    r_frame_done;

    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [3:0]              w_nib;
    logic [3:0]              w_bcd_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;
    logic                    w_dp_nxt;
    logic                    w_fd_nxt;

    assign bcd_out    = r_bcd_out;
    assign digit_sel  = r_digit_sel;
    assign dp_out     = r_dp_out;
    assign frame_done = r_frame_done;

    // Digit i (i>0) is a leading zero when it and every higher digit are zero.
    always_comb begin : lz_scan
        logic v_run;
        v_run     = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run        = v_run & (r_active_bcd[4*i +: 4] == 4'h0);
            w_lz_mask[i] = v_run;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_slot       <= '0;
            r_idx        <= '0;
            r_bcd_out    <= 4'hF;
            r_digit_sel  <= '0;
            r_dp_out     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_idx        <= w_idx_nxt;
            r_bcd_out    <= w_bcd_nxt;
            r_digit_sel  <= w_sel_nxt;
            r_dp_out     <= w_dp_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    // Outputs are computed from the next state so they line up with the registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_idx_nxt   = r_idx;
        w_sel_nxt   = '0;
        w_bcd_nxt   = 4'hF;
        w_dp_nxt    = 1'b0;
        w_fd_nxt    = 1'b0;
        w_nib       = 4'hF;

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_slot_nxt  = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_slot_nxt  = '0;
                    w_idx_nxt   = '0;
                end
                default: begin
                    if (r_slot == SLOT_LAST) begin
                        w_state_nxt = S_BLANK;
                        w_slot_nxt  = '0;
                        w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end else begin
                        w_slot_nxt  = r_slot + 1'b1;
                        w_state_nxt = (r_slot < BLANK_LAST) ? S_BLANK : S_DRIVE;
                    end
                end
            endcase
        end

        if (w_state_nxt == S_DRIVE) begin
            w_nib                = r_active_bcd[4*w_idx_nxt +: 4];
            w_sel_nxt[w_idx_nxt] = 1'b1;
            w_bcd_nxt            = (lz_blank && w_lz_mask[w_idx_nxt]) ? 4'hF : w_nib;
            w_dp_nxt             = r_active_dp[w_idx_nxt];
            w_fd_nxt             = (w_slot_nxt == SLOT_LAST) && (w_idx_nxt == IDX_LAST);
        end
    end

    // Active only changes at a frame boundary so a frame never shows a mix of two values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_active_bcd <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (load) begin
                r_shadow_bcd <= bcd_in;
                r_shadow_dp  <= dp_in;
            end
            if (load && (r_state == S_IDLE)) begin
                r_active_bcd <= bcd_in;
                r_active_dp  <= dp_in;
                r_pending    <= 1'b0;
            end else begin
                if (r_frame_done && r_pending) begin
                    r_active_bcd <= r_shadow_bcd;
                    r_active_dp  <= r_shadow_dp;
                end
                if (load) begin
                    r_pending <= 1'b1;
                end else if (r_frame_done) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard and vector-table bench for seg7_scan_ctrl.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        dp_out;
    logic        frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (4),
        .PRESCALE    (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .load      (load),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .lz_blank  (lz_blank),
        .bcd_out   (bcd_out),
        .digit_sel (digit_sel),
        .dp_out    (dp_out),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lz;
        logic [15:0] exp_nib;
    } vec_t;

    // Expected entry layout: {digit_sel[3:0], bcd_out[3:0], dp_out, frame_done}
    logic [9:0] sb_q[$];
    int         n_checks;
    int         n_fail;
    vec_t       vecs[7];

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back({4'b0000, 4'hF, 1'b0, 1'b0});
    endtask

    task automatic push_frame(input logic [15:0] nib, input logic [3:0] dp, input int n);
        int k;
        logic [3:0] sel;
        k = 0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (k < n) begin
                    sel = 4'b0001 << d;
                    if (c == 0) sb_q.push_back({4'b0000, 4'hF, 1'b0, 1'b0});
                    else sb_q.push_back({sel, nib[4*d +: 4], dp[d], (d == 3 && c == 3)});
                end
                k++;
            end
        end
    endtask

    task automatic check_cycle(input string name);
        logic [9:0] exp_v;
        logic [9:0] act_v;
        n_checks++;
        act_v = {digit_sel, bcd_out, dp_out, frame_done};
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got sel=%b bcd=%h dp=%b fd=%b",
                     name, digit_sel, bcd_out, dp_out, frame_done);
        end else begin
            exp_v = sb_q.pop_front();
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s @%0t: got sel=%b bcd=%h dp=%b fd=%b, expected sel=%b bcd=%h dp=%b fd=%b",
                         name, $time, act_v[9:6], act_v[5:2], act_v[1], act_v[0],
                         exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            check_cycle(name);
            @(negedge clk);
        end
    endtask

    task automatic check_dark(input string name);
        n_checks++;
        if ({digit_sel, bcd_out, dp_out, frame_done} !== {4'b0000, 4'hF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: got sel=%b bcd=%h dp=%b fd=%b, expected sel=0000 bcd=f dp=0 fd=0",
                     name, digit_sel, bcd_out, dp_out, frame_done);
        end
    endtask

    // Called at a negedge; returns at the negedge where frame cycle 1 is visible.
    task automatic load_idle(input logic [15:0] v, input logic [3:0] dp, input logic lz);
        en = 1'b0;
        @(negedge clk);
        en       = 1'b1;
        load     = 1'b1;
        bcd_in   = v;
        dp_in    = dp;
        lz_blank = lz;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{16'h0070, 4'b0000, 1'b1, 16'hFF70};
        vecs[1] = '{16'h0000, 4'b0000, 1'b1, 16'hFFF0};
        vecs[2] = '{16'h3141, 4'b0100, 1'b0, 16'h3141};
        vecs[3] = '{16'h0070, 4'b0000, 1'b0, 16'h0070};
        vecs[4] = '{16'hA0B0, 4'b0001, 1'b1, 16'hA0B0};
        vecs[5] = '{16'h0005, 4'b1000, 1'b1, 16'hFFF5};
        vecs[6] = '{16'h0100, 4'b0011, 1'b1, 16'hF100};

        reset_n  = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;
        lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        check_dark("reset_state");
        reset_n = 1'b1;
        @(negedge clk);
        check_dark("idle_after_reset");

        // Load from IDLE, two back-to-back frames
        load_idle(16'h1234, 4'b0000, 1'b0);
        push_frame(16'h1234, 4'b0000, 16);
        push_frame(16'h1234, 4'b0000, 16);
        run(32, "basic_1234");

        // Mid-frame load, then a load coincident with frame_done
        load_idle(16'h1234, 4'b0000, 1'b0);
        push_frame(16'h1234, 4'b0000, 16);
        push_frame(16'h5678, 4'b0000, 16);
        push_frame(16'h1111, 4'b0000, 16);
        run(6, "shadow_f1");
        load   = 1'b1;
        bcd_in = 16'h5678;
        run(1, "shadow_f1");
        load = 1'b0;
        run(8, "shadow_f1");
        load   = 1'b1;
        bcd_in = 16'h1111;
        run(1, "shadow_fd_coincident");
        load = 1'b0;
        run(32, "shadow_f2_f3");

        for (int v = 0; v < 7; v++) begin
            load_idle(vecs[v].bcd, vecs[v].dp, vecs[v].lz);
            push_frame(vecs[v].exp_nib, vecs[v].dp, 16);
            run(16, $sformatf("vec%0d", v));
        end

        // en dropped while digit 2 is driven
        load_idle(16'h9876, 4'b0000, 1'b0);
        push_frame(16'h9876, 4'b0000, 11);
        push_dark(3);
        push_frame(16'h9876, 4'b0000, 16);
        run(10, "en_drop_pre");
        en = 1'b0;
        run(1, "en_drop_pre");
        run(2, "en_drop_dark");
        en = 1'b1;
        run(1, "en_drop_dark");
        run(16, "en_restart");

        // Asynchronous reset while a digit is driven
        load_idle(16'h4321, 4'b0000, 1'b0);
        push_frame(16'h4321, 4'b0000, 3);
        run(3, "pre_async_reset");
        #2 reset_n = 1'b0;
        #1 check_dark("async_reset_dark");
        @(negedge clk);
        check_dark("async_reset_hold");
        reset_n = 1'b1;
        @(negedge clk);
        push_frame(16'h0000, 4'b0000, 16);
        run(16, "after_reset_zero");

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display.
- Shares one BCD-to-7-segment decoder (4-bit BCD in, 7-bit abcdefg out, active-high; any code above 9 decodes to all-off) across NUM_DIGITS digits.
- Each cycle it presents one digit's BCD nibble to the decoder and drives the matching one-hot digit enable.
- Sits between the numeric datapath (BCD counters, registers) and the display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 1000, clock cycles per digit slot (must be > BLANK_CYCLES).
- BLANK_CYCLES, 2, cycles at the start of each slot with all digits off (anti-ghosting guard, ≥1).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low forces the display dark.
- load  in  1  one-cycle strobe: capture bcd_in and dp_in into the shadow register.
- bcd_in  in  4*NUM_DIGITS  packed BCD value; nibble 0 (bits 3:0) is the least-significant digit.
- dp_in  in  NUM_DIGITS  decimal-point request per digit.
- lz_blank  in  1  leading-zero suppression enable (sampled live).
- bcd_out  out  4  nibble to the decoder; 4'hF means blank.
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high; all-zero means dark.
- dp_out  out  1  decimal point for the currently enabled digit.
- frame_done  out  1  one-cycle pulse at the end of each complete scan frame.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: bcd_out=4'hF, digit_sel=0, dp_out=0, frame_done=0.
  - Internal: shadow, active and pending registers cleared; state IDLE; slot counter and digit index = 0.
- Registers:
  - load=1 copies bcd_in/dp_in into shadow and sets pending.
  - active is copied from shadow, and pending is cleared, only on the cycle frame_done asserts. This prevents tearing mid-frame.
  - load coincident with frame_done: shadow takes the new value, active takes the old shadow, pending stays 1.
  - Exception: a load while in IDLE copies straight through to active.
- State machine: IDLE, BLANK, DRIVE. All outputs are registered.
  - IDLE: outputs held at reset values. en=1 → BLANK with digit index 0 and slot counter 0.
  - BLANK: lasts slot counter 0..BLANK_CYCLES-1. digit_sel=0, bcd_out=4'hF, dp_out=0. Then → DRIVE.
  - DRIVE: lasts slot counter BLANK_CYCLES..PRESCALE-1. digit_sel=one-hot(index), bcd_out=active nibble[index], dp_out=active dp[index].
  - End of slot: index increments and the FSM returns to BLANK. After index NUM_DIGITS-1 the index wraps to 0.
  - frame_done is high on the final DRIVE cycle of digit NUM_DIGITS-1 (cycle PRESCALE-1 of that slot).
- en deassert in any state: next cycle IDLE, outputs dark, counters cleared, pending kept. frame_done does not fire for a partial frame.
- Leading-zero suppression (lz_blank=1):
  - Digit i is blanked if it and every digit above it are 0, for i>0. Digit 0 is never suppressed.
  - A blanked digit drives bcd_out=4'hF with digit_sel still one-hot, so the slot timing is unchanged. dp_out is still driven from dp.
- Codes A..E pass through unchanged (the decoder blanks them). Code F in the data is indistinguishable from a blanked digit.
- Frame length = NUM_DIGITS*PRESCALE cycles exactly, with no dead cycles between frames.

Test Plan:
All cases use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
1. Reset, en=1, load bcd_in=16'h1234 from IDLE.
   - Expect per slot: 1 dark cycle, then 3 cycles of digit_sel=0001/bcd_out=4, 0010/3, 0100/2, 1000/1.
   - Expect frame_done on cycle 16 only; pattern repeats.
2. Mid-frame, load 16'h5678.
   - Expect the current frame to finish showing 1234.
   - Expect the next frame to show 8,7,6,5, with the switch exactly at frame_done.
3. lz_blank=1, value 16'h0070.
   - Expect digit 3 and digit 2 → bcd_out=F, digit 1 → 7, digit 0 → 0.
   - Value 16'h0000 → only digit 0 shows 0.
4. en dropped during the DRIVE phase of digit 2.
   - Expect next cycle digit_sel=0, bcd_out=F, no frame_done.
   - Re-enable → restart from a BLANK slot on digit 0.
5. dp_in=4'b0100, value 16'h3141.
   - Expect dp_out=1 only while digit_sel=0100.
   - Expect dp_out=0 in all BLANK cycles.
6. Assert reset_n low mid-DRIVE (asynchronously, off the clock edge).
   - Expect outputs dark immediately.
   - After release with en=1, expect 0000 displayed until the next load.
